ladybird_flash_loader: RTL and testbench

- Boot-time sequencer that copies a fixed image from the QSPI flash interface into on-chip memory.
- Issues single-byte flash reads on the flash bus port and packs four bytes into one 32-bit word. Writes each word to the memory bus port.
- Holds the core in reset until the copy is complete.
- Sits between the flash interface, the instruction/data RAM and the core reset input.

---
 rtl/ladybird_flash_loader_pkg.sv | 6 +
 rtl/ladybird_byte_packer.sv | 15 +
 rtl/ladybird_flash_loader.sv | 117 +++++++++++
 tb/tb_ladybird_flash_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ladybird_flash_loader_pkg.sv
// ladybird_flash_loader_pkg: state encoding and constants shared by the flash loader files.
package ladybird_flash_loader_pkg;
    typedef enum logic [2:0] {IDLE, FREQ, FWAIT, MWRITE, DONE} loader_state_t;
    localparam int FLASH_ARRAY_SPACE_BIT = 16;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/ladybird_byte_packer.sv
// ladybird_byte_packer: assembles little-endian 32-bit words one byte lane at a time.
module ladybird_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_in,
    output logic [31:0] word
);
    always_ff @(posedge clk) begin
        if (rst || clear) word <= '0;
        else if (load) word[{lane, 3'b000} +: 8] <= byte_in;
    end
endmodule

// File: rtl/ladybird_flash_loader.sv
// ladybird_flash_loader: boot copy of a flash image into RAM, holding the core in reset until done.
// Optional image checksum accumulator enabled by LADYBIRD_FLASH_LOADER_CHECKSUM_EN.
module ladybird_flash_loader
    import ladybird_flash_loader_pkg::*;
#(
    parameter int          LOAD_BYTES = 4096,
    parameter logic [15:0] FLASH_BASE = 16'h0000,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        core_rst,
    output logic        flash_req,
    input  logic        flash_gnt,
    output logic [31:0] flash_addr,
    output logic [3:0]  flash_wstrb,
    input  logic        flash_data_gnt,
    input  logic [31:0] flash_rdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] checksum
);
    loader_state_t state, state_next;
    logic [16:0] off;
    logic [31:0] pack;
    logic [15:0] flash_off;
    logic        done_q, core_rst_q, begin_copy, byte_take, unused_rdata;

    assign begin_copy   = state == IDLE && start;
    assign byte_take    = state == FWAIT && flash_data_gnt;
    assign flash_off    = FLASH_BASE + off[15:0];
    assign unused_rdata = ^flash_rdata[31:8];
    assign done         = done_q;
    assign core_rst     = core_rst_q;
    assign flash_wstrb  = 4'h0;
    assign mem_wstrb    = mem_req ? 4'hF : 4'h0;

    ladybird_byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (begin_copy),
        .load    (byte_take),
        .lane    (off[1:0]),
        .byte_in (flash_rdata[7:0]),
        .word    (pack)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            off        <= '0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state <= state_next;
            if (begin_copy) begin
                off        <= '0;
                done_q     <= 1'b0;
                core_rst_q <= 1'b1;
            end else if (byte_take) off <= off + 17'd1;
            if (state_next == DONE) begin
                done_q     <= 1'b1;
                core_rst_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        flash_req  = 1'b0;
        mem_req    = 1'b0;
        flash_addr = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: state_next = start ? FREQ : IDLE;
            FREQ: begin
                busy       = 1'b1;
                flash_req  = 1'b1;
                flash_addr = {{(32 - FLASH_ARRAY_SPACE_BIT){1'b0}}, flash_off};
                state_next = flash_gnt ? FWAIT : FREQ;
            end
            FWAIT: begin
                busy = 1'b1;
                if (flash_data_gnt) state_next = off[1:0] == 2'd3 ? MWRITE : FREQ;
            end
            MWRITE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                // off already counts the fourth byte, so step back one word
                mem_addr  = MEM_BASE + ({15'b0, off - 17'(WORD_BYTES)} & ~32'h3);
                mem_wdata = pack;
                if (mem_gnt) state_next = off == 17'(LOAD_BYTES) ? DONE : FREQ;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef LADYBIRD_FLASH_LOADER_CHECKSUM_EN
    logic [31:0] sum;
    always_ff @(posedge clk) begin
        if (rst || begin_copy) sum <= '0;
        else if (mem_req && mem_gnt) sum <= sum + mem_wdata;
    end
    assign checksum = sum;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_ladybird_flash_loader.sv
// tb_ladybird_flash_loader: randomized flash/memory bus models checked against an image-level reference.
module tb_ladybird_flash_loader;
    localparam int          LOAD  = 16;
    localparam int          WORDS = LOAD / 4;
    localparam logic [15:0] FB    = 16'hFFF0;
    localparam logic [31:0] MB    = 32'h0000_0100;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic busy, done, core_rst, flash_req, flash_gnt, flash_data_gnt, mem_req, mem_gnt;
    logic [31:0] flash_addr, flash_rdata, mem_addr, mem_wdata, checksum;
    logic [3:0]  flash_wstrb, mem_wstrb;

    ladybird_flash_loader #(.LOAD_BYTES(LOAD), .FLASH_BASE(FB), .MEM_BASE(MB)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .core_rst(core_rst),
        .flash_req(flash_req), .flash_gnt(flash_gnt), .flash_addr(flash_addr),
        .flash_wstrb(flash_wstrb), .flash_data_gnt(flash_data_gnt), .flash_rdata(flash_rdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    logic [7:0] img [LOAD];
    int f_pct = 100, m_pct = 100, lat_max = 0, copy_id = 0;
    bit f_hold = 0, m_hold = 0, spur = 0;

    int rd_idx = 0, wr_idx = 0, falls = 0, seen_id = 0, wait_n = 0;
    bit pend = 0, acc_f = 0, f_stall = 0, m_stall = 0, prev_cr = 1;
    logic [7:0]  pend_byte;
    logic [31:0] f_prev, m_prev_addr, m_prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int w);
        int b = (w % WORDS) * 4;
        return {img[b + 3], img[b + 2], img[b + 1], img[b]};
    endfunction

    function automatic logic [31:0] model_sum();
        logic [31:0] s = '0;
        for (int w = 0; w < WORDS; w++) s += exp_word(w);
        return s;
    endfunction

    // Bus models: grants decided at negedge, so a handshake seen here is certain at the next posedge.
    always @(negedge clk) begin
        if (prev_cr && !core_rst) begin
            falls++;
            chk("core_rst_fall_after_last_write", wr_idx, WORDS);
        end
        prev_cr = core_rst;
        if (seen_id != copy_id) begin
            seen_id = copy_id;
            rd_idx = 0;
            wr_idx = 0;
            falls = 0;
        end
        flash_data_gnt = 1'b0;
        flash_rdata = $urandom;
        if (rst) begin
            pend = 0; acc_f = 0; f_stall = 0; m_stall = 0;
            flash_gnt = 1'b0;
            mem_gnt = 1'b0;
        end else begin
            if (f_stall) begin
                chk("flash_req_held", flash_req, 1);
                chk("flash_addr_held", flash_addr, f_prev);
            end
            if (m_stall) begin
                chk("mem_req_held", mem_req, 1);
                chk("mem_addr_held", mem_addr, m_prev_addr);
                chk("mem_wdata_held", mem_wdata, m_prev_data);
            end
            chk("mem_wstrb", mem_wstrb, mem_req ? 4'hF : 4'h0);
            if (flash_req) begin
                chk("flash_bit16", flash_addr[16], 0);
                chk("flash_wstrb", flash_wstrb, 0);
            end
            if (acc_f) begin
                pend = 1;
                wait_n = $urandom_range(0, lat_max);
            end
            if (pend) begin
                if (wait_n == 0) begin
                    flash_data_gnt = 1'b1;
                    flash_rdata[7:0] = pend_byte;
                    pend = 0;
                end else wait_n--;
            end else if (spur && $urandom_range(0, 2) == 0) flash_data_gnt = 1'b1;
            flash_gnt = !f_hold && $urandom_range(1, 100) <= f_pct;
            mem_gnt = !m_hold && $urandom_range(1, 100) <= m_pct;
            acc_f = flash_req && flash_gnt;
            f_stall = flash_req && !flash_gnt;
            f_prev = flash_addr;
            m_stall = mem_req && !mem_gnt;
            m_prev_addr = mem_addr;
            m_prev_data = mem_wdata;
            if (acc_f) begin
                chk("flash_addr_seq", flash_addr, {16'h0, 16'(FB + 16'(rd_idx))});
                pend_byte = img[rd_idx % LOAD];
                rd_idx++;
            end
            if (mem_req && mem_gnt) begin
                chk("mem_addr_seq", mem_addr, MB + 32'(4 * wr_idx));
                chk("mem_wdata_seq", mem_wdata, exp_word(wr_idx));
                wr_idx++;
            end
        end
    end

    task automatic set_image(input int kind);
        for (int i = 0; i < LOAD; i++)
            case (kind)
                0: img[i] = 8'(i);
                1: img[i] = i == 0 ? 8'h01 : i == 4 ? 8'h02 : (i >= 8 && i < 12) ? 8'hFF : 8'h00;
                3: img[i] = 8'hFF;
                default: img[i] = 8'($urandom);
            endcase
    endtask

    task automatic start_copy();
        copy_id++;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_start", busy, 1);
        chk("done_clear_on_start", done, 0);
        chk("core_rst_on_start", core_rst, 1);
    endtask

    task automatic finish_copy(input logic [31:0] exp_sum);
        int n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("copy_completes", n < 2000, 1);
        chk("done_busy", busy, 0);
        chk("done_core_rst", core_rst, 0);
        chk("words_written", wr_idx, WORDS);
        chk("bytes_read", rd_idx, LOAD);
`ifdef LADYBIRD_FLASH_LOADER_CHECKSUM_EN
        chk("checksum", checksum, exp_sum);
`else
        chk("checksum_off", checksum, 32'h0 & exp_sum);
`endif
        @(posedge clk); #1;
        chk("done_sticky", done, 1);
        chk("core_rst_sticky", core_rst, 0);
        chk("idle_busy", busy, 0);
        chk("core_rst_falls", falls, 1);
    endtask

    typedef struct {
        int          kind;
        int          fp;
        int          mp;
        int          lat;
        bit          spur;
        bit          use_tab;
        logic [31:0] sum;
    } vec_t;
    vec_t tab [6];

    initial begin
        tab[0] = '{0, 100, 100, 0, 1'b0, 1'b1, 32'h24201C18};
        tab[1] = '{1, 100, 100, 0, 1'b1, 1'b1, 32'h00000002};
        tab[2] = '{3, 50, 50, 3, 1'b1, 1'b1, 32'hFFFFFFFC};
        tab[3] = '{2, 60, 70, 2, 1'b1, 1'b0, 32'h0};
        tab[4] = '{2, 30, 30, 4, 1'b0, 1'b0, 32'h0};
        tab[5] = '{0, 40, 60, 1, 1'b1, 1'b1, 32'h24201C18};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_flash_req", flash_req, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_flash_addr", flash_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_checksum", checksum, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) begin
            set_image(tab[r].kind);
            f_pct = tab[r].fp;
            m_pct = tab[r].mp;
            lat_max = tab[r].lat;
            spur = tab[r].spur;
            start_copy();
            finish_copy(tab[r].use_tab ? tab[r].sum : model_sum());
        end

        // Stalled flash grant then stalled memory grant.
        set_image(0);
        f_pct = 100; m_pct = 100; lat_max = 0; spur = 0;
        f_hold = 1;
        start_copy();
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_flash_req", flash_req, 1);
            chk("stall_flash_addr", flash_addr, {16'h0, FB});
        end
        m_hold = 1;
        f_hold = 0;
        for (int n = 0; n < 100 && !mem_req; n++) begin
            @(posedge clk); #1;
        end
        repeat (3) begin
            chk("stall_mem_req", mem_req, 1);
            chk("stall_mem_addr", mem_addr, MB);
            chk("stall_mem_wdata", mem_wdata, 32'h03020100);
            @(posedge clk); #1;
        end
        m_hold = 0;
        finish_copy(32'h24201C18);

        // Reset while byte 2 of word 1 is being requested.
        lat_max = 1;
        start_copy();
        for (int n = 0; n < 200 && rd_idx != 6; n++) begin
            @(posedge clk); #1;
        end
        f_hold = 1;
        for (int n = 0; n < 20 && !flash_req; n++) begin
            @(posedge clk); #1;
        end
        chk("midrst_req_before", flash_req, 1);
        chk("midrst_addr_before", flash_addr, {16'h0, 16'(FB + 16'd6)});
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_flash_req", flash_req, 0);
        chk("midrst_core_rst", core_rst, 1);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        f_hold = 0;
        @(posedge clk); #1;
        start_copy();
        finish_copy(32'h24201C18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
